// File: rtl/aes_encrypt.sv
// Byte-serial AES-128 encryption core: loads 16 bytes, runs 10 rounds through one
// shared S-box, streams 16 ciphertext bytes out, then idles until the next reset.
module aes_encrypt #(
  parameter logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] input_data,
  output logic [7:0] output_data,
  output logic       output_ready
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  typedef enum logic [2:0] {LOAD, KS, SB, MIX, OUT, DONE} phase_t;

  phase_t       phase;
  logic [3:0]   cnt;
  logic [3:0]   round;
  logic [7:0]   st [16];
  logic [127:0] rk;
  logic [31:0]  tmp;

  logic [7:0]   sbox_in;
  logic [7:0]   sbox_out;
  logic [7:0]   rcon;
  logic [31:0]  w0n, w1n, w2n, w3n;
  logic [127:0] nk;
  logic [7:0]   sr  [16];
  logic [7:0]   mc  [16];
  logic [7:0]   nst [16];

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  always_comb begin
    case (round)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  // Shared S-box: RotWord(w3) bytes during KS, state bytes otherwise
  always_comb begin
    sbox_in = st[cnt];
    if (phase == KS) begin
      case (cnt[1:0])
        2'd0: sbox_in = rk[23:16];
        2'd1: sbox_in = rk[15:8];
        2'd2: sbox_in = rk[7:0];
        2'd3: sbox_in = rk[31:24];
      endcase
    end
  end

  assign sbox_out = SBOX[sbox_in];

  always_comb begin
    w0n = rk[127:96] ^ tmp ^ {rcon, 24'h000000};
    w1n = rk[95:64] ^ w0n;
    w2n = rk[63:32] ^ w1n;
    w3n = rk[31:0]  ^ w2n;
    nk  = {w0n, w1n, w2n, w3n};
  end

  // ShiftRows: row r of column c comes from column (c+r)%4
  always_comb begin
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr[4'(4*c + r)] = st[4'(4*((c + r) % 4) + r)];
      end
    end
  end

  always_comb begin
    for (int c = 0; c < 4; c++) begin
      mc[4'(4*c)]     = xtime(sr[4'(4*c)]) ^ xtime(sr[4'(4*c+1)]) ^ sr[4'(4*c+1)]
                      ^ sr[4'(4*c+2)] ^ sr[4'(4*c+3)];
      mc[4'(4*c+1)]   = sr[4'(4*c)] ^ xtime(sr[4'(4*c+1)]) ^ xtime(sr[4'(4*c+2)])
                      ^ sr[4'(4*c+2)] ^ sr[4'(4*c+3)];
      mc[4'(4*c+2)]   = sr[4'(4*c)] ^ sr[4'(4*c+1)] ^ xtime(sr[4'(4*c+2)])
                      ^ xtime(sr[4'(4*c+3)]) ^ sr[4'(4*c+3)];
      mc[4'(4*c+3)]   = xtime(sr[4'(4*c)]) ^ sr[4'(4*c)] ^ sr[4'(4*c+1)]
                      ^ sr[4'(4*c+2)] ^ xtime(sr[4'(4*c+3)]);
    end
  end

  // Final round bypasses MixColumns; AddRoundKey uses the freshly finished key
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      nst[i] = ((round == 4'd10) ? sr[i] : mc[i]) ^ nk[7'(127 - 8*i) -: 8];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase        <= LOAD;
      cnt          <= 4'd0;
      round        <= 4'd0;
      rk           <= KEY;
      tmp          <= 32'h0;
      output_data  <= 8'h00;
      output_ready <= 1'b0;
      for (int i = 0; i < 16; i++) st[i] <= 8'h00;
    end else begin
      case (phase)
        LOAD: begin
          st[cnt] <= input_data ^ rk[{4'd15 - cnt, 3'b000} +: 8];
          cnt     <= cnt + 4'd1;
          if (cnt == 4'd15) begin
            phase <= KS;
            round <= 4'd1;
          end
        end
        KS: begin
          tmp[{~cnt[1:0], 3'b000} +: 8] <= sbox_out;
          if (cnt == 4'd3) begin
            cnt   <= 4'd0;
            phase <= SB;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        SB: begin
          st[cnt] <= sbox_out;
          cnt     <= cnt + 4'd1;
          if (cnt == 4'd15) phase <= MIX;
        end
        MIX: begin
          for (int i = 0; i < 16; i++) st[i] <= nst[i];
          rk <= nk;
          if (round == 4'd10) begin
            phase        <= OUT;
            output_data  <= nst[0];
            output_ready <= 1'b1;
            cnt          <= 4'd1;
          end else begin
            round <= round + 4'd1;
            phase <= KS;
            cnt   <= 4'd0;
          end
        end
        OUT: begin
          output_data <= st[cnt];
          cnt         <= cnt + 4'd1;
          if (cnt == 4'd15) phase <= DONE;
        end
        DONE: begin
          output_data  <= 8'h00;
          output_ready <= 1'b0;
        end
        default: phase <= DONE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_encrypt.sv
// Bench for aes_encrypt: two instances (default key and FIPS-197 appendix B key)
// compared against known vectors and a GF(2^8)-arithmetic AES reference model.
module tb_aes_encrypt;

  localparam logic [127:0] KEY0 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KEY1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in0 = 8'h00;
  logic [7:0] in1 = 8'h00;
  logic [7:0] d0, d1;
  logic       r0, r1;

  int errors = 0;
  int checks = 0;

  logic [7:0] sbox_t [256];

  typedef struct {
    logic [127:0] pt0;
    logic [127:0] exp0;
    logic [127:0] pt1;
    logic [127:0] exp1;
    bit           noise;
  } vec_t;

  vec_t vecs [6];

  always #5 clk = ~clk;

  aes_encrypt #(.KEY(KEY0)) dut0 (
    .clk(clk), .rst(rst), .input_data(in0), .output_data(d0), .output_ready(r0)
  );

  aes_encrypt #(.KEY(KEY1)) dut1 (
    .clk(clk), .rst(rst), .input_data(in1), .output_data(d1), .output_ready(r1)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box from its definition: multiplicative inverse followed by the affine map
  function automatic logic [7:0] sbox_calc(input logic [7:0] x);
    logic [7:0] inv = 8'h00;
    logic [7:0] s;
    for (int y = 1; y < 256; y++) begin
      if (x != 8'h00 && gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
    end
    s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
        ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    return s;
  endfunction

  function automatic logic [127:0] aes_ref(input logic [127:0] key, input logic [127:0] pt);
    logic [7:0]   w [176];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   tw [4];
    logic [7:0]   rc;
    logic [7:0]   hold;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) w[i] = key[127 - 8*i -: 8];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      for (int j = 0; j < 4; j++) tw[j] = w[4*(i-1) + j];
      if (i % 4 == 0) begin
        hold  = tw[0];
        tw[0] = sbox_t[tw[1]] ^ rc;
        tw[1] = sbox_t[tw[2]];
        tw[2] = sbox_t[tw[3]];
        tw[3] = sbox_t[hold];
        rc    = gmul(rc, 8'h02);
      end
      for (int j = 0; j < 4; j++) w[4*i + j] = w[4*(i-4) + j] ^ tw[j];
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8] ^ w[i];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) s[i] = sbox_t[s[i]];
      for (int c = 0; c < 4; c++)
        for (int q = 0; q < 4; q++) t[4*c + q] = s[4*((c + q) % 4) + q];
      for (int c = 0; c < 4; c++) begin
        if (r < 10) begin
          s[4*c]   = gmul(t[4*c], 8'h02) ^ gmul(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 8'h02) ^ gmul(t[4*c+2], 8'h03) ^ t[4*c+3];
          s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 8'h02) ^ gmul(t[4*c+3], 8'h03);
          s[4*c+3] = gmul(t[4*c], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 8'h02);
        end else begin
          for (int q = 0; q < 4; q++) s[4*c + q] = t[4*c + q];
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[16*r + i];
    end
    for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = s[i];
    return res;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_quiet(input string name);
    check(name, {14'b0, r0, r1, d0, d1}, 32'h0);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    check_quiet("reset_quiet");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Called on a falling edge with rst just released
  task automatic load(input logic [127:0] p0, input logic [127:0] p1);
    for (int i = 0; i < 16; i++) begin
      in0 = p0[127 - 8*i -: 8];
      in1 = p1[127 - 8*i -: 8];
      @(posedge clk);
      #1;
      check_quiet("load_quiet");
      @(negedge clk);
    end
  endtask

  task automatic collect(input logic [127:0] e0, input logic [127:0] e1, input bit noise);
    int k = 0;
    bit seen = 1'b0;
    while (!seen && k < 300) begin
      @(posedge clk);
      #1;
      k++;
      if (noise) begin
        in0 = 8'($urandom);
        in1 = 8'($urandom);
      end
      if (r0 || r1) seen = 1'b1;
      else check_quiet("round_quiet");
    end
    check("latency", 32'(k), 32'd210);
    for (int j = 0; j < 16; j++) begin
      if (j > 0) begin
        @(posedge clk);
        #1;
        if (noise) begin
          in0 = 8'($urandom);
          in1 = 8'($urandom);
        end
      end
      check("out_ready", {30'b0, r0, r1}, 32'h3);
      check("out_byte_key0", {24'b0, d0}, {24'b0, e0[127 - 8*j -: 8]});
      check("out_byte_key1", {24'b0, d1}, {24'b0, e1[127 - 8*j -: 8]});
    end
    repeat (4) begin
      @(posedge clk);
      #1;
      if (noise) begin
        in0 = 8'($urandom);
        in1 = 8'($urandom);
      end
      check_quiet("done_quiet");
    end
  endtask

  initial begin
    int k;
    for (int i = 0; i < 256; i++) sbox_t[i] = sbox_calc(8'(i));

    vecs[0] = '{pt0: 128'h00112233445566778899aabbccddeeff, exp0: 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                pt1: 128'h3243f6a8885a308d313198a2e0370734, exp1: 128'h3925841d02dc09fbdc118597196a0b32,
                noise: 1'b0};
    vecs[1].pt0 = '0;
    vecs[1].pt1 = '1;
    vecs[1].noise = 1'b0;
    vecs[2] = vecs[0];
    vecs[2].noise = 1'b1;
    for (int v = 3; v < 6; v++) begin
      vecs[v].pt0   = {$urandom, $urandom, $urandom, $urandom};
      vecs[v].pt1   = {$urandom, $urandom, $urandom, $urandom};
      vecs[v].noise = 1'($urandom_range(0, 1));
    end
    for (int v = 1; v < 6; v++) begin
      if (v != 2) begin
        vecs[v].exp0 = aes_ref(KEY0, vecs[v].pt0);
        vecs[v].exp1 = aes_ref(KEY1, vecs[v].pt1);
      end
    end

    @(negedge clk);
    for (int v = 0; v < 6; v++) begin
      pulse_reset();
      load(vecs[v].pt0, vecs[v].pt1);
      collect(vecs[v].exp0, vecs[v].exp1, vecs[v].noise);
    end

    // Abort about 50 cycles into the rounds, then a clean block
    pulse_reset();
    load(vecs[3].pt0, vecs[3].pt1);
    repeat (50) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_quiet("abort_round");
    @(negedge clk);
    pulse_reset();
    load(vecs[0].pt0, vecs[0].pt1);
    collect(vecs[0].exp0, vecs[0].exp1, 1'b0);

    // Abort while ciphertext is streaming: outputs must clear asynchronously
    pulse_reset();
    load(vecs[4].pt0, vecs[4].pt1);
    k = 0;
    while (r0 !== 1'b1 && k < 300) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("abort_wait_ready", {31'b0, r0}, 32'h1);
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_quiet("abort_out");
    @(negedge clk);
    pulse_reset();
    load(vecs[1].pt0, vecs[1].pt1);
    collect(vecs[1].exp0, vecs[1].exp1, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aes_encrypt.md
Name: aes_encrypt

Overview:
- Low-area, byte-serial AES-128 encryption core (FIPS-197), 10 rounds, fixed 128-bit key set by parameter.
- After each reset, loads one 16-byte plaintext block at one byte per clock, encrypts it with a single shared S-box, then streams the 16-byte ciphertext out one byte per clock with a valid strobe.
- One block per reset: the next block requires another reset pulse.

Parameters:
- KEY, 128'h000102030405060708090a0b0c0d0e0f, AES-128 cipher key; KEY[127:120] is key byte 0.

Ports:
- clk  input  1  system clock, rising-edge active
- rst  input  1  reset, asynchronous, active-high
- input_data  input  8  plaintext byte stream
- output_data  output  8  ciphertext byte stream
- output_ready  output  1  high while output_data holds a valid ciphertext byte

Behaviour:
- One clock (clk). rst is asynchronous and active-high. While rst=1: state and counters cleared, round key reloaded from KEY, FSM=LOAD, output_data=8'h00, output_ready=0.
- Byte order is FIPS-197 order: byte i maps to state[row=i%4][col=i/4]. Byte 0 is first in and first out.
- LOAD, 16 cycles:
  - The first rising edge with rst=0 captures byte 0. The next 15 edges capture bytes 1..15.
  - Initial AddRoundKey is applied on capture: stored byte = input_data ^ KEY byte i.
  - input_data is don't-care outside LOAD.
- ROUND r=1..10, 21 cycles each:
  - KS, 4 cycles: the shared S-box computes SubWord(RotWord(w3)) one byte per cycle into a temporary word.
  - SB, 16 cycles: the shared S-box substitutes state bytes 0..15, one per cycle.
  - MIX, 1 cycle:
    - Finish the next round key: w0' = w0 ^ temp ^ {Rcon[r],24'h0}, w1' = w1 ^ w0', w2' = w2 ^ w1', w3' = w3 ^ w2'.
    - State = AddRoundKey(MixColumns(ShiftRows(state))) with the new key.
    - MixColumns is skipped in round 10.
  - Rcon sequence: 01,02,04,08,10,20,40,80,1b,36.
- OUT, 16 cycles:
  - output_data is registered and presents ciphertext bytes 0..15 on consecutive cycles.
  - output_ready=1 for exactly those 16 cycles.
  - output_ready rises 210 clocks after the edge that captured byte 15.
- DONE:
  - output_ready=0 and output_data=8'h00.
  - Holds until the next rst.
  - Further input_data is ignored.
- Reset mid-operation (any state): immediate abort, with no partial output. The next block loads cleanly after rst is released.
- The S-box is a single 256-entry combinational lookup shared by KS and SB; there is no second instance. MixColumns uses xtime: shift left, XOR 8'h1b when the MSB is set.
- Cycle count per block: 16 load + 210 compute + 16 out = 242 clocks from reset release to the last output byte.

Test Plan:
- Default KEY. Reset, then feed 00 11 22 33 44 55 66 77 88 99 aa bb cc dd ee ff on 16 consecutive cycles -> output_ready high for 16 cycles starting 210 clocks after the last byte, streaming 69 c4 e0 d8 6a 7b 04 30 d8 cd b7 80 70 b4 c5 5a.
- KEY=128'h2b7e151628aed2a6abf7158809cf4f3c. Feed 32 43 f6 a8 88 5a 30 8d 31 31 98 a2 e0 37 07 34 -> output 39 25 84 1d 02 dc 09 fb dc 11 85 97 19 6a 0b 32.
- Back-to-back blocks: after the first block's output, pulse rst, then repeat the first vector -> identical ciphertext, proving full state/key reinitialisation.
- Reset mid-compute: assert rst about 50 cycles into ROUND -> output_ready and output_data go 0 immediately (asynchronously). After release, a fresh block produces the correct ciphertext.
- Reset values and quiet output: check output_ready=0 and output_data=00 during rst, LOAD, ROUND and DONE. Check output_ready is never high outside the 16 OUT cycles.
- Input ignored after load: toggle input_data randomly during ROUND and DONE -> ciphertext unchanged.
